// File: rtl/alu_accumulator.sv
// Accumulator datapath slice: WIDTH-bit accumulator plus a combinational add/and/or/xor ALU.
// Define ALU_FLAG_REG_EN to register the status flags on ALU writebacks instead of driving them combinationally.
module alu_accumulator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tin,
    input  logic [WIDTH-1:0] pin,
    input  logic             uacc,
    input  logic             inmode,
    input  logic             outmode,
    input  logic [1:0]       cmode,
    output logic [WIDTH-1:0] bus,
    output logic [2:0]       flgs
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [2:0]       alu_flags;

    assign sum = {1'b0, acc_q} + {1'b0, tin};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (cmode)
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            OP_AND:  alu_res = acc_q & tin;
            OP_OR:   alu_res = acc_q | tin;
            OP_XOR:  alu_res = acc_q ^ tin;
            default: alu_res = '0;
        endcase
    end

    // Flag order on the port: {sign, zero, carry}.
    assign alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_carry};

    always_comb begin
        acc_d = acc_q;
        if (uacc) begin
            acc_d = inmode ? pin : alu_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign bus = outmode ? alu_res : acc_q;

`ifdef ALU_FLAG_REG_EN
    logic [2:0] flgs_q;
    logic [2:0] flgs_d;

    // Capture only the flags of a result that is actually written back to the accumulator.
    always_comb begin
        flgs_d = flgs_q;
        if (uacc && !inmode) begin
            flgs_d = alu_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flgs_q <= '0;
        end else begin
            flgs_q <= flgs_d;
        end
    end

    assign flgs = flgs_q;
`else
    assign flgs = alu_flags;
`endif

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator (default build, combinational flags).
module tb_alu_accumulator;

    logic       clk;
    logic       rst_n;
    logic [3:0] tin;
    logic [3:0] pin;
    logic       uacc;
    logic       inmode;
    logic       outmode;
    logic [1:0] cmode;
    logic [3:0] bus;
    logic [2:0] flgs;

    int vectors;
    int miscompares;

    alu_accumulator #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tin     (tin),
        .pin     (pin),
        .uacc    (uacc),
        .inmode  (inmode),
        .outmode (outmode),
        .cmode   (cmode),
        .bus     (bus),
        .flgs    (flgs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle away from it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_acc(input logic [3:0] val);
        pin    = val;
        inmode = 1'b1;
        uacc   = 1'b1;
        cycle();
        uacc   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tin = 4'd0; pin = 4'd0; uacc = 1'b0;
        inmode = 1'b0; outmode = 1'b0; cmode = 2'b00;
        #1;
        vectors++;
        if (bus !== 4'd0) begin miscompares++; $display("FAIL reset_bus got=%0d exp=0", bus); end
        vectors++;
        if (flgs !== 3'b010) begin miscompares++; $display("FAIL reset_flgs got=%b exp=010", flgs); end
        cycle();
        cycle();
        #3 rst_n = 1'b1;
        cycle();
        vectors++;
        if (bus !== 4'd0) begin miscompares++; $display("FAIL reset_release_hold got=%0d exp=0", bus); end
    endtask

    task automatic test_load_add();
        load_acc(4'd2);
        outmode = 1'b0;
        #1;
        vectors++;
        if (bus !== 4'd2) begin miscompares++; $display("FAIL load_pin got=%0d exp=2", bus); end
        tin = 4'd1; cmode = 2'b00; outmode = 1'b1;
        #1;
        vectors++;
        if (bus !== 4'd3) begin miscompares++; $display("FAIL add_bus got=%0d exp=3", bus); end
        vectors++;
        if (flgs !== 3'b000) begin miscompares++; $display("FAIL add_flgs got=%b exp=000", flgs); end
        inmode = 1'b0; uacc = 1'b1;
        cycle();
        uacc = 1'b0; outmode = 1'b0;
        #1;
        vectors++;
        if (bus !== 4'd3) begin miscompares++; $display("FAIL add_writeback got=%0d exp=3", bus); end
    endtask

    task automatic test_hold();
        uacc = 1'b0; pin = 4'd9; tin = 4'd7; inmode = 1'b1;
        cycle();
        inmode = 1'b0;
        cycle();
        vectors++;
        if (bus !== 4'd3) begin miscompares++; $display("FAIL hold_acc got=%0d exp=3", bus); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_vals [3];
        exp_vals[0] = 4'd5; exp_vals[1] = 4'd7; exp_vals[2] = 4'd9;
        tin = 4'd2; cmode = 2'b00; inmode = 1'b0; outmode = 1'b0; uacc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if (bus !== exp_vals[i]) begin
                miscompares++;
                $display("FAIL repeat_add_%0d got=%0d exp=%0d", i, bus, exp_vals[i]);
            end
        end
        uacc = 1'b0;
    endtask

    task automatic test_and_zero();
        load_acc(4'd14);
        outmode = 1'b0;
        #1;
        vectors++;
        if (bus !== 4'd14) begin miscompares++; $display("FAIL and_load got=%0d exp=14", bus); end
        tin = 4'd1; cmode = 2'b01; outmode = 1'b1;
        #1;
        vectors++;
        if (bus !== 4'd0) begin miscompares++; $display("FAIL and_bus got=%0d exp=0", bus); end
        vectors++;
        if (flgs !== 3'b010) begin miscompares++; $display("FAIL and_flgs got=%b exp=010", flgs); end
        inmode = 1'b0; uacc = 1'b1;
        cycle();
        uacc = 1'b0; outmode = 1'b0;
        #1;
        vectors++;
        if (bus !== 4'd0) begin miscompares++; $display("FAIL and_writeback got=%0d exp=0", bus); end
    endtask

    task automatic test_add_sign_carry();
        tin = 4'd15; cmode = 2'b00; outmode = 1'b1;
        #1;
        vectors++;
        if (bus !== 4'd15) begin miscompares++; $display("FAIL sign_bus got=%0d exp=15", bus); end
        vectors++;
        if (flgs !== 3'b100) begin miscompares++; $display("FAIL sign_flgs got=%b exp=100", flgs); end
        inmode = 1'b0; uacc = 1'b1;
        cycle();
        uacc = 1'b0;
        #1;
        // acc = 15, 15 + 15 = 30 -> result 14 (1110) with carry out; MSB set.
        vectors++;
        if (bus !== 4'd14) begin miscompares++; $display("FAIL carry_bus got=%0d exp=14", bus); end
        vectors++;
        if (flgs !== 3'b101) begin miscompares++; $display("FAIL carry_flgs got=%b exp=101", flgs); end
        outmode = 1'b0;
        #1;
        vectors++;
        if (bus !== 4'd15) begin miscompares++; $display("FAIL sign_writeback got=%0d exp=15", bus); end
    endtask

    task automatic test_or_xor();
        load_acc(4'b0101);
        tin = 4'b0011; outmode = 1'b1; cmode = 2'b10;
        #1;
        vectors++;
        if (bus !== 4'b0111) begin miscompares++; $display("FAIL or_bus got=%b exp=0111", bus); end
        vectors++;
        if (flgs !== 3'b000) begin miscompares++; $display("FAIL or_flgs got=%b exp=000", flgs); end
        cmode = 2'b11;
        #1;
        vectors++;
        if (bus !== 4'b0110) begin miscompares++; $display("FAIL xor_bus got=%b exp=0110", bus); end
        vectors++;
        if (flgs !== 3'b000) begin miscompares++; $display("FAIL xor_flgs got=%b exp=000", flgs); end
        cmode = 2'b01;
        #1;
        vectors++;
        if (bus !== 4'b0001) begin miscompares++; $display("FAIL and_nz_bus got=%b exp=0001", bus); end
        tin = 4'b1100; cmode = 2'b00;
        #1;
        // 0101 + 1100 = 1_0001: carry out, nonzero, MSB clear.
        vectors++;
        if (flgs !== 3'b001) begin miscompares++; $display("FAIL add_wrap_flgs got=%b exp=001", flgs); end
    endtask

    task automatic test_async_reset();
        outmode = 1'b0; tin = 4'd1; cmode = 2'b00; inmode = 1'b0; uacc = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus !== 4'd0) begin miscompares++; $display("FAIL async_reset_now got=%0d exp=0", bus); end
        cycle();
        vectors++;
        if (bus !== 4'd0) begin miscompares++; $display("FAIL async_reset_held got=%0d exp=0", bus); end
        #3 rst_n = 1'b1;
        #1;
        vectors++;
        if (bus !== 4'd0) begin miscompares++; $display("FAIL async_release_idle got=%0d exp=0", bus); end
        cycle();
        vectors++;
        if (bus !== 4'd1) begin miscompares++; $display("FAIL async_first_update got=%0d exp=1", bus); end
        uacc = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_load_add();
        test_hold();
        test_back_to_back();
        test_and_zero();
        test_add_sign_carry();
        test_or_xor();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
